boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_boot_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Byte-stream boot loader: receives a framed program image, writes it word by word
// into RAM, verifies an XOR checksum and releases the core reset on success.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_busy,
  output logic        core_nrst,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [7:0] HeaderByte = 8'hA5;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenLo = 3'd1;
  localparam logic [2:0] StLenHi = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StCksum = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StError = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] count_q, count_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        rx_ready_q;
  logic        core_nrst_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic        timed;
  logic        timeout_hit;
  logic [15:0] len_full;
  logic [31:0] next_word;
  logic [15:0] count_inc;

  assign accept    = rx_valid & rx_ready_q;
  assign len_full  = {rx_data, len_q[7:0]};
  assign next_word = {rx_data, buf_q[31:8]};
  assign count_inc = count_q + 16'd1;

  // Only states waiting on the host are subject to the inter-byte gap limit.
  assign timed = (state_q == StLenLo) || (state_q == StLenHi) ||
                 (state_q == StData)  || (state_q == StCksum);
  assign timeout_hit = timed && !accept && (gap_q == TIMEOUT - 1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    buf_d      = buf_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    gap_d      = (accept || !timed) ? 32'd0 : gap_q + 32'd1;

    case (state_q)
      StIdle, StError: begin
        if (accept && rx_data == HeaderByte) begin
          state_d = StLenLo;
          count_d = 16'd0;
          xor_d   = 8'd0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d   = {8'h00, rx_data};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d      = len_full;
          byte_cnt_d = 2'd0;
          if (len_full == 16'd0) begin
            state_d = StCksum;
          end else if ({16'h0000, len_full} > MAX_WORDS) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          buf_d      = next_word;
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'h0000, count_q, 2'b00};
            wdata_d = next_word;
          end
        end
      end
      StWrite: begin
        // Address, data and enable stay frozen until the RAM takes the word.
        if (!ram_busy) begin
          we_d    = 1'b0;
          count_d = count_inc;
          state_d = (count_inc == len_q) ? StCksum : StData;
        end
      end
      StCksum: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? StDone : StError;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (timeout_hit) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      len_q       <= 16'd0;
      buf_q       <= 32'd0;
      byte_cnt_q  <= 2'd0;
      xor_q       <= 8'd0;
      count_q     <= 16'd0;
      gap_q       <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      rx_ready_q  <= 1'b1;
      core_nrst_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      buf_q       <= buf_d;
      byte_cnt_q  <= byte_cnt_d;
      xor_q       <= xor_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rx_ready_q  <= (state_d != StWrite) && (state_d != StDone);
      // Lags done by one cycle so the core sees a clean edge after the image is final.
      core_nrst_q <= (state_q == StDone);
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StError);
    end
  end

  assign rx_ready   = rx_ready_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_we     = we_q;
  assign core_nrst  = core_nrst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed + randomized bench for boot_loader with a frame-level reference model.
module tb_boot_loader;

  localparam int unsigned MaxWords = 8;
  localparam int unsigned Timeout  = 40;
  localparam logic [31:0] Base     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_busy = 1'b0;
  logic        core_nrst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  logic force_busy = 1'b0;
  logic rand_busy = 1'b0;
  logic rand_gap = 1'b0;

  logic [7:0]  pay_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] cap_addr_q[$];
  logic [31:0] cap_data_q[$];
  logic        exp_ok;
  int          exp_words;

  boot_loader #(
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxWords),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_busy  (ram_busy),
    .core_nrst (core_nrst),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ram_busy = force_busy | (rand_busy && ($urandom_range(0, 2) == 0));
  end

  // RAM-side monitor: a write lands on any cycle with we=1 and busy=0.
  always @(negedge clk) begin
    if (nrst && ram_we && !ram_busy) begin
      cap_addr_q.push_back(ram_addr);
      cap_data_q.push_back(ram_wdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("send_stall", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, ram_addr, 32'd0);
    check({tag, "_wdata"}, ram_wdata, 32'd0);
    check({tag, "_core_nrst"}, 32'(core_nrst), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] x = 8'h00;
    foreach (pay_q[i]) x ^= pay_q[i];
    return x;
  endfunction

  // Reference model: frame bytes, expected writes and outcome from the frame rules.
  task automatic build_frame(input int n, input bit use_ovr, input logic [7:0] ck_ovr);
    logic [7:0] ck;
    logic [7:0] sent;
    frame_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n > int'(MaxWords)) begin
      exp_ok    = 1'b0;
      exp_words = 0;
      return;
    end
    ck   = payload_xor();
    sent = use_ovr ? ck_ovr : ck;
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
    frame_q.push_back(sent);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(Base + 32'(4 * i));
      exp_data_q.push_back({pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
    end
    exp_ok    = (sent == ck);
    exp_words = n;
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    for (int i = 0; i < 4 * n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_frame(input string tag);
    int waited = 0;
    cap_addr_q.delete();
    cap_data_q.delete();
    foreach (frame_q[i]) begin
      if (rand_gap) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      send_byte(frame_q[i]);
    end
    @(negedge clk);
    while (!(done || error) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ended"}, 32'(done | error), 32'd1);
    check({tag, "_core_nrst_lag"}, 32'(core_nrst), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_ok));
    check({tag, "_error"}, 32'(error), 32'(!exp_ok));
    check({tag, "_core_nrst"}, 32'(core_nrst), 32'(exp_ok));
    check({tag, "_wc"}, 32'(word_count), 32'(exp_words));
    check({tag, "_nwrites"}, 32'(cap_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < cap_addr_q.size(); i++) begin
      check({tag, "_addr"}, cap_addr_q[i], exp_addr_q[i]);
      check({tag, "_data"}, cap_data_q[i], exp_data_q[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] ck;

    // Reset and the basic two-word load.
    do_reset("rst0");
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    build_frame(2, 1'b1, 8'h88);
    run_frame("good2");
    do_reset("rst_after_done");

    // Same frame, wrong checksum: writes happen, then error.
    build_frame(2, 1'b1, 8'h00);
    run_frame("badck");
    do_reset("rst1");

    // RAM busy for a long stretch during the first write.
    cap_addr_q.delete();
    cap_data_q.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    force_busy = 1'b1;
    send_byte(8'h44);
    for (int k = 0; k < int'(Timeout) + 10; k++) begin
      @(negedge clk);
      if (k < 5) begin
        check("busy_we", 32'(ram_we), 32'd1);
        check("busy_addr", ram_addr, Base);
        check("busy_wdata", ram_wdata, 32'h44332211);
        check("busy_rx_ready", 32'(rx_ready), 32'd0);
      end
    end
    check("busy_no_timeout", 32'(error), 32'd0);
    check("busy_still_we", 32'(ram_we), 32'd1);
    force_busy = 1'b0;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'h88);
    @(negedge clk);
    check("busy_done", 32'(done), 32'd1);
    check("busy_wc", 32'(word_count), 32'd2);
    check("busy_nwrites", 32'(cap_addr_q.size()), 32'd2);
    if (cap_data_q.size() == 2) check("busy_w1", cap_data_q[1], 32'h88776655);
    do_reset("rst2");

    // Inter-byte timeout inside DATA, then recovery with a full frame.
    cap_addr_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    repeat (Timeout - 1) @(negedge clk);
    check("to_early", 32'(error), 32'd0);
    repeat (5) @(negedge clk);
    check("to_error", 32'(error), 32'd1);
    check("to_nowrite", 32'(cap_addr_q.size()), 32'd0);
    check("to_core_nrst", 32'(core_nrst), 32'd0);
    @(posedge clk);
    #1;
    fill_random(3);
    build_frame(3, 1'b0, 8'h00);
    run_frame("to_recover");
    do_reset("rst3");

    // Junk bytes in IDLE, then a zero-length frame.
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    check("junk_error", 32'(error), 32'd0);
    check("junk_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    pay_q.delete();
    build_frame(0, 1'b0, 8'h00);
    run_frame("n0");
    do_reset("rst4");

    // Length above the limit, then reset in the middle of a stalled write.
    send_byte(8'hA5);
    send_byte(8'(MaxWords + 1));
    send_byte(8'h00);
    @(negedge clk);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_wc", 32'(word_count), 32'd0);
    @(posedge clk);
    #1;
    force_busy = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check("midwr_we", 32'(ram_we), 32'd1);
    check("midwr_error", 32'(error), 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_vals("midwr_rst");
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized frames with random RAM stalls and inter-byte gaps.
    rand_busy = 1'b1;
    rand_gap  = 1'b1;
    for (int t = 0; t < 10; t++) begin
      n = (t == 3) ? int'(MaxWords) : int'($urandom_range(0, MaxWords + 1));
      if (n <= int'(MaxWords)) fill_random(n);
      else pay_q.delete();
      ck = payload_xor();
      if ($urandom_range(0, 3) == 0) build_frame(n, 1'b1, ck ^ 8'h5A);
      else build_frame(n, 1'b0, 8'h00);
      run_frame("rand");
      do_reset("rand_rst");
    end
    rand_busy = 1'b0;
    rand_gap  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
